// File: rtl/ccsds_asm_randomizer.sv
// CCSDS channel framer: prepends the attached sync marker to each LDPC codeword
// and optionally XORs the codeword bits with the CCSDS pseudo-random sequence.
module ccsds_asm_randomizer #(
   parameter logic [31:0] ASM     = 32'h1ACFFC1D,
   parameter bit          RAND_EN = 1'b1,
   parameter int          CW_LEN  = 8160
) (
   input  logic clk,
   input  logic rst,
   input  logic s_axis_tdata,
   input  logic s_axis_tvalid,
   output logic s_axis_tready,
   input  logic s_axis_tlast,
   output logic m_axis_tdata,
   output logic m_axis_tvalid,
   input  logic m_axis_tready,
   output logic m_axis_tlast,
   output logic len_err
);

   localparam logic [15:0] LAST_N = 16'(CW_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t      state_r;
   state_t      state_next_s;
   logic [4:0]  k_r;
   logic [15:0] n_r;
   logic [7:0]  lfsr_r;
   logic        len_err_r;

   logic        m_xfer_s;
   logic        data_xfer_s;
   logic        frame_end_s;
   logic        at_last_s;
   logic        len_bad_s;

   // lfsr holds p(n)..p(n+7) with p(n) in bit 7; p(n+8) = p(n+7)^p(n+5)^p(n+3)^p(n)
   function automatic logic [7:0] pn_step(input logic [7:0] sr);
      return {sr[6:0], sr[7] ^ sr[4] ^ sr[2] ^ sr[0]};
   endfunction

   assign m_xfer_s    = m_axis_tvalid & m_axis_tready;
   assign data_xfer_s = (state_r == DATA) & m_xfer_s;
   assign frame_end_s = data_xfer_s & m_axis_tlast;
   assign at_last_s   = (n_r == LAST_N);
   assign len_bad_s   = s_axis_tlast ^ at_last_s;
   assign len_err     = len_err_r;

   // State, counters, randomizer and length-error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         k_r       <= 5'd0;
         n_r       <= 16'd0;
         lfsr_r    <= 8'hFF;
         len_err_r <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         len_err_r <= data_xfer_s & len_bad_s;
         if ((state_r == SYNC) && m_axis_tready) begin
            k_r <= k_r + 5'd1;
         end
         if (frame_end_s) begin
            k_r    <= 5'd0;
            n_r    <= 16'd0;
            lfsr_r <= 8'hFF;
         end else if (data_xfer_s) begin
            n_r    <= n_r + 16'd1;
            lfsr_r <= pn_step(lfsr_r);
         end
      end
   end

   // Next-state decision
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (s_axis_tvalid) begin
               state_next_s = SYNC;
            end else begin
               state_next_s = IDLE;
            end
         end
         SYNC: begin
            if (m_axis_tready && (k_r == 5'd31)) begin
               state_next_s = DATA;
            end else begin
               state_next_s = SYNC;
            end
         end
         DATA: begin
            if (frame_end_s) begin
               state_next_s = s_axis_tvalid ? SYNC : IDLE;
            end else begin
               state_next_s = DATA;
            end
         end
         default: state_next_s = IDLE;
      endcase
   end

   // Output decode; DATA is a zero-latency pass-through of the handshake
   always_comb begin
      m_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tdata  = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state_r)
         IDLE: begin
            m_axis_tvalid = 1'b0;
         end
         SYNC: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = ASM[5'd31 - k_r];
         end
         DATA: begin
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            m_axis_tdata  = s_axis_tdata ^ (RAND_EN & lfsr_r[7]);
            m_axis_tlast  = s_axis_tvalid & (s_axis_tlast | at_last_s);
         end
         default: begin
            m_axis_tvalid = 1'b0;
         end
      endcase
   end

endmodule
